frame_read_arbiter: RTL and testbench

- Shares the single read port of the camera frame-buffer BRAM between two requesters: the host (the Avalon pixel-readback path) and the accelerator image fetch (image index stream).
- It replaces a static select flag with cycle-by-cycle arbitration, a return-tag pipeline and a starvation guard.
- Grants are blocked while the camera writer owns the port.

---
 rtl/frame_read_arbiter.sv | 148 ++++++++++++++
 tb/tb_frame_read_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_read_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_read_arbiter                                                         |
// | Shares the frame-buffer BRAM read port between host readback and the       |
// | accelerator fetch, with a starvation guard and a return-tag pipeline.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module frame_read_arbiter #(
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 8,
   parameter int MEM_LAT       = 2,
   parameter int HOST_MAX_WAIT = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_busy_i,
   input  logic              host_req_i,
   input  logic [ADDR_W-1:0] host_addr_i,
   output logic              host_gnt_o,
   output logic              host_rvalid_o,
   output logic [DATA_W-1:0] host_rdata_o,
   input  logic              acc_req_i,
   input  logic [ADDR_W-1:0] acc_addr_i,
   output logic              acc_gnt_o,
   output logic              acc_rvalid_o,
   output logic [DATA_W-1:0] acc_rdata_o,
   output logic              mem_rd_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [7:0]        host_wait_max_o
);

   localparam logic [0:0] ST_ACC_PRIO   = 1'b0;
   localparam logic [0:0] ST_HOST_FORCE = 1'b1;
   localparam logic [7:0] C_WAIT_SAT    = 8'hFF;
   localparam logic [7:0] C_WAIT_LIMIT  = 8'(HOST_MAX_WAIT);

   logic                run_q;
   logic [0:0]          state_q, state_d;
   logic [7:0]          wait_q, wait_d;
   logic [7:0]          wait_max_q, wait_max_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [MEM_LAT-1:0]  vld_q, vld_d;
   logic [MEM_LAT-1:0]  own_q, own_d;
   logic [DATA_W-1:0]   host_rdata_q, acc_rdata_q;

   logic                w_arb_ok;
   logic                w_host_gnt;
   logic                w_acc_gnt;
   logic                w_issue;

   // run_q keeps every grant low until one clean edge has passed after reset.
   always_comb begin
      w_arb_ok   = run_q & ~wr_busy_i;
      w_host_gnt = 1'b0;
      w_acc_gnt  = 1'b0;
      if (w_arb_ok) begin
         if (state_q == ST_HOST_FORCE) begin
            w_host_gnt = host_req_i;
            w_acc_gnt  = acc_req_i & ~host_req_i;
         end else begin
            w_acc_gnt  = acc_req_i;
            w_host_gnt = host_req_i & ~acc_req_i;
         end
      end
   end

   assign w_issue = w_host_gnt | w_acc_gnt;

   always_comb begin
      wait_d = wait_q;
      if (!host_req_i || w_host_gnt) begin
         wait_d = '0;
      end else if (w_arb_ok && (wait_q != C_WAIT_SAT)) begin
         wait_d = wait_q + 8'd1;
      end
   end

   assign wait_max_d = (wait_q > wait_max_q) ? wait_q : wait_max_q;

   // The FSM is frozen while the writer owns the port.
   always_comb begin
      state_d = state_q;
      if (w_arb_ok) begin
         case (state_q)
            ST_ACC_PRIO: begin
               if (wait_d >= C_WAIT_LIMIT) begin
                  state_d = ST_HOST_FORCE;
               end
            end
            default: begin
               if (w_host_gnt || !host_req_i) begin
                  state_d = ST_ACC_PRIO;
               end
            end
         endcase
      end
   end

   always_comb begin
      vld_d    = vld_q;
      own_d    = own_q;
      vld_d[0] = w_issue;
      own_d[0] = w_host_gnt;
      for (int i = 1; i < MEM_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         own_d[i] = own_q[i-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         run_q        <= 1'b0;
         state_q      <= ST_ACC_PRIO;
         wait_q       <= '0;
         wait_max_q   <= '0;
         addr_q       <= '0;
         vld_q        <= '0;
         own_q        <= '0;
         host_rdata_q <= '0;
         acc_rdata_q  <= '0;
      end else begin
         run_q        <= 1'b1;
         state_q      <= state_d;
         wait_q       <= wait_d;
         wait_max_q   <= wait_max_d;
         addr_q       <= mem_addr_o;
         vld_q        <= vld_d;
         own_q        <= own_d;
         host_rdata_q <= host_rdata_o;
         acc_rdata_q  <= acc_rdata_o;
      end
   end

   assign host_gnt_o      = w_host_gnt;
   assign acc_gnt_o       = w_acc_gnt;
   assign mem_rd_en_o     = w_issue;
   assign mem_addr_o      = w_host_gnt ? host_addr_i :
                            (w_acc_gnt ? acc_addr_i : addr_q);
   assign host_rvalid_o   = vld_q[MEM_LAT-1] & own_q[MEM_LAT-1];
   assign acc_rvalid_o    = vld_q[MEM_LAT-1] & ~own_q[MEM_LAT-1];
   // Read data is a passthrough; the side that does not own the return holds.
   assign host_rdata_o    = host_rvalid_o ? mem_rdata_i : host_rdata_q;
   assign acc_rdata_o     = acc_rvalid_o  ? mem_rdata_i : acc_rdata_q;
   assign host_wait_max_o = wait_max_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_read_arbiter.sv
`default_nettype none
// Testbench for frame_read_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level reference model.
module tb_frame_read_arbiter;

   localparam int ADDR_W        = 16;
   localparam int DATA_W        = 8;
   localparam int MEM_LAT       = 2;
   localparam int HOST_MAX_WAIT = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              wr_busy = 1'b0;
   logic              host_req = 1'b0;
   logic [ADDR_W-1:0] host_addr = '0;
   logic              acc_req = 1'b0;
   logic [ADDR_W-1:0] acc_addr = '0;
   logic              host_gnt, host_rvalid, acc_gnt, acc_rvalid, mem_rd_en;
   logic [DATA_W-1:0] host_rdata, acc_rdata, mem_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        host_wait_max;

   frame_read_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .HOST_MAX_WAIT(HOST_MAX_WAIT)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .wr_busy_i(wr_busy),
      .host_req_i(host_req), .host_addr_i(host_addr), .host_gnt_o(host_gnt),
      .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
      .acc_req_i(acc_req), .acc_addr_i(acc_addr), .acc_gnt_o(acc_gnt),
      .acc_rvalid_o(acc_rvalid), .acc_rdata_o(acc_rdata),
      .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
      .host_wait_max_o(host_wait_max)
   );

   always #5 clk = ~clk;

   // Memory: returns addr[7:0] MEM_LAT cycles after a read, noise otherwise.
   logic [ADDR_W-1:0] mp [MEM_LAT];
   always @(posedge clk) begin
      mp[0] <= mem_rd_en ? mem_addr : 16'($urandom);
      for (int i = 1; i < MEM_LAT; i++) mp[i] <= mp[i-1];
   end
   assign mem_rdata = mp[MEM_LAT-1][7:0];

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      int              due;
      logic            host;
      logic [15:0]     addr;
   } rd_t;

   rd_t         m_q[$];
   bit          m_en;
   bit          m_forced;
   int          m_wait;
   int          m_wmax;
   logic [7:0]  m_hrd, m_ard;
   logic [15:0] m_maddr;
   int          cyc = 0;

   logic        g_h, g_a;
   logic        obs_h, obs_a, obs_hv, obs_av;
   int          obs_cyc;
   logic        p_hr = 1'b0, p_ar = 1'b0;
   logic [15:0] p_ha, p_aa;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_host_gnt"},    32'(host_gnt), 0);
      chk({tag, "_acc_gnt"},     32'(acc_gnt), 0);
      chk({tag, "_host_rvalid"}, 32'(host_rvalid), 0);
      chk({tag, "_acc_rvalid"},  32'(acc_rvalid), 0);
      chk({tag, "_host_rdata"},  32'(host_rdata), 0);
      chk({tag, "_acc_rdata"},   32'(acc_rdata), 0);
      chk({tag, "_mem_rd_en"},   32'(mem_rd_en), 0);
      chk({tag, "_mem_addr"},    32'(mem_addr), 0);
      chk({tag, "_wait_max"},    32'(host_wait_max), 0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; wr_busy = 1'b0;
      host_req = 1'b1; host_addr = 16'h00AA; acc_req = 1'b1; acc_addr = 16'h00BB;
      #1 chk_all_zero("rst_assert");
      m_q.delete();
      m_forced = 0; m_wait = 0; m_wmax = 0;
      m_hrd = '0; m_ard = '0; m_maddr = '0;
      @(negedge clk);
      #1 chk_all_zero("rst_hold");
      rst_n = 1'b1;
      #1 chk_all_zero("rst_release");
      host_req = 1'b0; acc_req = 1'b0;
      p_hr = 1'b0; p_ar = 1'b0; g_h = 1'b0; g_a = 1'b0;
      m_en = 1;
   endtask

   // One clock cycle: drive, compare against the model, advance the model.
   task automatic tick(input logic b, input logic hr, input logic [15:0] ha,
                       input logic ar, input logic [15:0] aa);
      logic eh, ea, ehv, eav;
      logic [15:0] eaddr;
      rd_t e;
      @(negedge clk);
      if (p_hr && !g_h && hr) begin
         assert (ha === p_ha) else begin
            errors++;
            $error("FAIL protocol_host_addr: observed %0h expected %0h", ha, p_ha);
         end
      end
      if (p_ar && !g_a && ar) begin
         assert (aa === p_aa) else begin
            errors++;
            $error("FAIL protocol_acc_addr: observed %0h expected %0h", aa, p_aa);
         end
      end
      wr_busy = b; host_req = hr; host_addr = ha; acc_req = ar; acc_addr = aa;
      #1;
      eh = 1'b0; ea = 1'b0;
      if (m_en && !b) begin
         if (m_forced) begin eh = hr; ea = ar && !hr; end
         else          begin ea = ar; eh = hr && !ar; end
      end
      eaddr = eh ? ha : (ea ? aa : m_maddr);
      ehv = (m_q.size() > 0) && (m_q[0].due == cyc) && m_q[0].host;
      eav = (m_q.size() > 0) && (m_q[0].due == cyc) && !m_q[0].host;
      if (ehv) m_hrd = m_q[0].addr[7:0];
      if (eav) m_ard = m_q[0].addr[7:0];
      chk("host_gnt", 32'(host_gnt), 32'(eh));
      chk("acc_gnt", 32'(acc_gnt), 32'(ea));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(eh | ea));
      chk("mem_addr", 32'(mem_addr), 32'(eaddr));
      chk("host_rvalid", 32'(host_rvalid), 32'(ehv));
      chk("acc_rvalid", 32'(acc_rvalid), 32'(eav));
      chk("host_rdata", 32'(host_rdata), 32'(m_hrd));
      chk("acc_rdata", 32'(acc_rdata), 32'(m_ard));
      chk("host_wait_max", 32'(host_wait_max), 32'(m_wmax));
      obs_h = host_gnt; obs_a = acc_gnt; obs_hv = host_rvalid; obs_av = acc_rvalid;
      obs_cyc = cyc;
      if (ehv || eav) void'(m_q.pop_front());
      if (eh || ea) begin
         e.due = cyc + MEM_LAT; e.host = eh; e.addr = eaddr;
         m_q.push_back(e);
      end
      m_maddr = eaddr;
      if (m_wait > m_wmax) m_wmax = m_wait;
      if (!hr || eh)           m_wait = 0;
      else if (m_en && !b)     m_wait = (m_wait < 255) ? m_wait + 1 : 255;
      if (m_en && !b) begin
         if (m_forced) begin
            if (eh || !hr) m_forced = 0;
         end else if (m_wait >= HOST_MAX_WAIT) begin
            m_forced = 1;
         end
      end
      g_h = eh; g_a = ea;
      p_hr = hr; p_ha = ha; p_ar = ar; p_aa = aa;
      cyc++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ha, aa;
      logic hr, ar, b;
      int n_av, first_av, last_av, s0, seq;

      apply_reset();

      // Reset while a read is in flight: its return must never appear.
      tick(0, 0, 16'h0, 1, 16'h0010);
      chk("midflight_acc_gnt", 32'(obs_a), 1);
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         tick(0, 0, 16'h0, 0, 16'h0);
         chk("midflight_no_acc_rvalid", 32'(obs_av), 0);
      end

      // Single host read.
      tick(0, 1, 16'h1234, 0, 16'h0);
      chk("single_host_gnt", 32'(obs_h), 1);
      tick(0, 0, 16'h1234, 0, 16'h0);
      chk("single_no_early_rvalid", 32'(obs_hv), 0);
      tick(0, 0, 16'h1234, 0, 16'h0);
      chk("single_host_rvalid", 32'(obs_hv), 1);
      chk("single_host_rdata", 32'(host_rdata), 32'h34);
      chk("single_acc_rvalid", 32'(obs_av), 0);
      tick(0, 0, 16'h1234, 0, 16'h0);

      // Contention: host forced through every HOST_MAX_WAIT+1 cycles.
      ha = 16'h2000; aa = 16'h3000;
      for (int k = 0; k < 3 * (HOST_MAX_WAIT + 1); k++) begin
         tick(0, 1, ha, 1, aa);
         chk("contention_host_gnt", 32'(obs_h), 32'((k % (HOST_MAX_WAIT + 1)) == HOST_MAX_WAIT));
         chk("contention_acc_gnt", 32'(obs_a), 32'((k % (HOST_MAX_WAIT + 1)) != HOST_MAX_WAIT));
         if (g_h) ha++;
         if (g_a) aa++;
      end
      chk("contention_wait_max", 32'(host_wait_max), HOST_MAX_WAIT);

      // Writer block: wait counter frozen, grants resume immediately.
      for (int k = 0; k < 3; k++) begin
         tick(0, 1, ha, 1, aa);
         if (g_a) aa++;
      end
      for (int k = 0; k < 5; k++) begin
         tick(1, 1, ha, 1, aa);
         chk("busy_no_host_gnt", 32'(obs_h), 0);
         chk("busy_no_acc_gnt", 32'(obs_a), 0);
         chk("busy_no_rd_en", 32'(mem_rd_en), 0);
      end
      for (int k = 0; k < HOST_MAX_WAIT - 2; k++) begin
         tick(0, 1, ha, 1, aa);
         chk("post_busy_host_gnt", 32'(obs_h), 32'(k == HOST_MAX_WAIT - 3));
         chk("post_busy_acc_gnt", 32'(obs_a), 32'(k != HOST_MAX_WAIT - 3));
         if (g_h) ha++;
         if (g_a) aa++;
      end
      for (int k = 0; k < MEM_LAT + 2; k++) tick(0, 0, ha, 0, aa);

      // Streaming 784 consecutive accelerator reads.
      n_av = 0; first_av = -1; last_av = -1; s0 = cyc; seq = 0;
      for (int i = 0; i < 784 + MEM_LAT + 2; i++) begin
         if (i < 784) begin
            tick(0, 0, ha, 1, 16'(i));
            chk("stream_acc_gnt", 32'(obs_a), 1);
         end else begin
            tick(0, 0, ha, 0, 16'(783));
         end
         if (obs_av) begin
            n_av++;
            if (first_av < 0) first_av = obs_cyc;
            last_av = obs_cyc;
            chk("stream_order", 32'(acc_rdata), 32'(seq[7:0]));
            seq++;
         end
      end
      chk("stream_count", n_av, 784);
      chk("stream_latency", first_av - s0, MEM_LAT);
      chk("stream_no_gaps", last_av - first_av, 783);

      // Withdrawn host request while starved.
      aa = 16'h6000;
      for (int k = 0; k < 2; k++) begin tick(0, 0, ha, 1, aa); aa++; end
      for (int k = 0; k < 3; k++) begin
         tick(0, 1, 16'h4444, 1, aa);
         chk("withdraw_no_host_gnt", 32'(obs_h), 0);
         aa++;
      end
      for (int k = 0; k < MEM_LAT + 2; k++) begin
         tick(0, 0, 16'h4444, 1, aa);
         chk("withdraw_no_host_rvalid", 32'(obs_hv), 0);
         aa++;
      end
      for (int k = 0; k < HOST_MAX_WAIT + 1; k++) begin
         tick(0, 1, 16'h5555, 1, aa);
         chk("withdraw_restart_host_gnt", 32'(obs_h), 32'(k == HOST_MAX_WAIT));
         if (g_a) aa++;
      end
      for (int k = 0; k < MEM_LAT + 2; k++) tick(0, 0, ha, 0, aa);

      // Random traffic obeying the request/hold protocol.
      hr = 0; ar = 0; ha = '0; aa = '0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            apply_reset();
            hr = 0; ar = 0;
         end
         b = ($urandom_range(0, 9) < 2);
         if (hr && !g_h) begin
            if ($urandom_range(0, 19) == 0) hr = 0;
         end else begin
            hr = ($urandom_range(0, 2) != 0);
            ha = 16'($urandom);
         end
         if (ar && !g_a) begin
            if ($urandom_range(0, 19) == 0) ar = 0;
         end else begin
            ar = ($urandom_range(0, 9) < 8);
            aa = 16'($urandom);
         end
         tick(b, hr, ha, ar, aa);
      end
      for (int k = 0; k < MEM_LAT + 2; k++) tick(0, 0, ha, 0, aa);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
